// File: rtl/wb_arbiter2_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
// Bus geometry is fixed here so the interface and arbiter agree on widths.
package wb_arb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Returns 1 when master 1 should win; ties go to whoever was not served last.
    function automatic logic next_owner(input logic last, input logic req0, input logic req1);
        if (req0 && req1) begin
            return ~last;
        end
        return req1;
    endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone bundle; master drives the request, slave drives the response.
interface if_wb (
    input logic clk,
    input logic rst
);
    import wb_arb_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_SW-1:0] sel;
    logic [WB_DW-1:0] dat_m;
    logic [WB_DW-1:0] dat_s;
    logic             ack;
    logic             stall;

    modport master (
        input  clk, rst,
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack, stall
    );

    modport slave (
        input  clk, rst,
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, stall
    );

endinterface

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between two masters.
// Ownership is held while the owner keeps cyc high or responses are still in flight.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter  int MAX_OUT = 4,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic  clk,
    input  logic  rst_n,
    if_wb.slave   m0,
    if_wb.slave   m1,
    if_wb.master  s
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_GNT0 = GNT0;
    localparam logic [1:0] ST_GNT1 = GNT1;

    logic [1:0]       state;
    logic             last;
    logic [CNT_W-1:0] cnt;

    logic own0;
    logic own1;
    logic busy;
    logic full;
    logic accept;
    logic retire;

    assign own0   = (state == ST_GNT0);
    assign own1   = (state == ST_GNT1);
    assign busy   = (cnt != '0);
    assign full   = (cnt == CNT_W'(MAX_OUT));
    assign accept = s.stb & ~s.stall;
    assign retire = s.ack & (own0 | own1) & busy;

    // The slave sees only the owner; a non-owner is held off with stall and never sees ack.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.sel    = '0;
        s.dat_m  = '0;
        m0.ack   = 1'b0;
        m0.stall = 1'b1;
        m0.dat_s = s.dat_s;
        m1.ack   = 1'b0;
        m1.stall = 1'b1;
        m1.dat_s = s.dat_s;
        if (own0) begin
            s.cyc    = m0.cyc | busy;
            s.stb    = m0.stb & ~full;
            s.we     = m0.we;
            s.adr    = m0.adr;
            s.sel    = m0.sel;
            s.dat_m  = m0.dat_m;
            m0.stall = s.stall | full;
            m0.ack   = s.ack;
        end else if (own1) begin
            s.cyc    = m1.cyc | busy;
            s.stb    = m1.stb & ~full;
            s.we     = m1.we;
            s.adr    = m1.adr;
            s.sel    = m1.sel;
            s.dat_m  = m1.dat_m;
            m1.stall = s.stall | full;
            m1.ack   = s.ack;
        end
    end

    // Release waits for cnt==0 so no response can be routed to the wrong master.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(accept) - CNT_W'(retire);
            case (state)
                ST_IDLE: begin
                    if (m0.cyc || m1.cyc) begin
                        state <= next_owner(last, m0.cyc, m1.cyc) ? ST_GNT1 : ST_GNT0;
                    end
                end
                ST_GNT0: begin
                    if (!m0.cyc && !busy) begin
                        last  <= 1'b0;
                        state <= m1.cyc ? ST_GNT1 : ST_IDLE;
                    end
                end
                ST_GNT1: begin
                    if (!m1.cyc && !busy) begin
                        last  <= 1'b1;
                        state <= m0.cyc ? ST_GNT0 : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // An ack in the first cycle after reset belongs to an aborted cycle and is excused.
    a_ack_needs_owner: assert property (
        @(posedge clk) disable iff (!rst_n)
        (s.ack && $past(rst_n)) |-> (state != ST_IDLE)
    );

    a_ack_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n)
        (s.ack && state != ST_IDLE) |-> busy
    );

endmodule
